// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical memory port between the I-cache and the
// D-cache. It transfers one cacheline per transaction, either a fill read or a
// dirty writeback.
//
// Optional feature macro: PMEM_ARB_ROUND_ROBIN_EN.
//   Undefined (default): fixed priority. D wins when both caches are pending.
//   Defined: alternating priority, tracked in a last_grant register. On a tie
//            the requester that was not granted last time wins.
//
// Handshake: a cache holds read or write high until it sees its resp pulse.
// The winning request is copied into hold registers at grant, and only those
// registers drive the memory port until pmem_resp. The resp pulse goes
// combinationally to the granted cache, in the same cycle as pmem_resp.
// One IDLE cycle always separates two transactions, so the served cache can
// drop its request before the next arbitration.
//
// dbg_state exposes the FSM: 0 = IDLE, 1 = SERVE_I, 2 = SERVE_D.
module pmem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic                  i_pmem_write,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   hold_read_q, hold_read_d;
   logic                   hold_write_q, hold_write_d;
   logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
   logic [LINE_WIDTH-1:0]  hold_wdata_q, hold_wdata_d;

   logic i_pend;
   logic d_pend;
   logic grant_d;

   assign i_pend = i_pmem_read | i_pmem_write;
   assign d_pend = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
   // Encodes the requester granted most recently: 0 = I, 1 = D.
   logic last_grant_q, last_grant_d;

   // Decide the winner: on a tie, pick the requester not granted last time.
   always_comb begin
      grant_d = d_pend;
      if (i_pend && d_pend) begin
         grant_d = ~last_grant_q;
      end
   end
`else
   // Decide the winner: D has fixed priority over I.
   always_comb begin
      grant_d = d_pend;
   end
`endif

   // Next-state logic: capture the winner in IDLE, and forward resp while serving.
   always_comb begin
      state_d      = state_q;
      hold_read_d  = hold_read_q;
      hold_write_d = hold_write_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_pend || d_pend) begin
               if (grant_d) begin
                  // If a cache raises read and write together, the write wins.
                  hold_write_d = d_pmem_write;
                  hold_read_d  = d_pmem_read & ~d_pmem_write;
                  hold_addr_d  = d_pmem_address;
                  hold_wdata_d = d_pmem_wdata;
                  state_d      = SERVE_D;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                  last_grant_d = 1'b1;
`endif
               end else begin
                  hold_write_d = i_pmem_write;
                  hold_read_d  = i_pmem_read & ~i_pmem_write;
                  hold_addr_d  = i_pmem_address;
                  hold_wdata_d = i_pmem_wdata;
                  state_d      = SERVE_I;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                  last_grant_d = 1'b0;
`endif
               end
            end
         end
         SERVE_I: begin
            i_pmem_resp = pmem_resp;
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            d_pmem_resp = pmem_resp;
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and hold registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_read_q  <= 1'b0;
         hold_write_q <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         hold_read_q  <= hold_read_d;
         hold_write_q <= hold_write_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
      end
   end

`ifdef PMEM_ARB_ROUND_ROBIN_EN
   // Round-robin history register. After reset it reads I, so D wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Memory strobes come only from the hold registers, and only while serving.
   assign pmem_read    = (state_q != IDLE) & hold_read_q;
   assign pmem_write   = (state_q != IDLE) & hold_write_q;
   assign pmem_address = hold_addr_q;
   assign pmem_wdata   = hold_wdata_q;

   // Read data goes to both caches; only the resp pulse qualifies it.
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: drives randomized I/D cache requests against a reactive
// memory model. A round-level reference model predicts the grant order and
// pushes the expected memory transactions. A monitor checks each observed
// transaction against those predictions, cycle by cycle.
module tb_pmem_arbiter;

   logic         clk;
   logic         rst;
   logic         i_pmem_read, i_pmem_write;
   logic [15:0]  i_pmem_address;
   logic [127:0] i_pmem_wdata, i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read, d_pmem_write;
   logic [15:0]  d_pmem_address;
   logic [127:0] d_pmem_wdata, d_pmem_rdata;
   logic         d_pmem_resp;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
   logic [1:0]   dbg_state;

   pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
      .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .dbg_state(dbg_state)
   );

   // One expected memory transaction.
   // id: 0 = I, 1 = D. issue: cycle the request was presented (0 = chained).
   typedef struct packed {
      logic         id;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wd;
      logic [31:0]  issue;
   } txn_t;

   txn_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_end = -100;
   bit   rr_last = 1'b0;
   bit   mem_slow = 1'b0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   // A cache must never raise read and write together.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(i_pmem_read && i_pmem_write) && !(d_pmem_read && d_pmem_write))
            else $error("illegal read+write from one requester");
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] mem_line(input logic [15:0] a);
      return {a, 16'hDEAD, a, 16'hBEEF, ~a, 16'hC0DE, a ^ 16'h5A5A, 16'h1234};
   endfunction

   function automatic logic [127:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- memory model ----------------
   // Responds after a random latency. Occasionally it pulses resp while
   // idle (a spurious resp).
   initial begin
      int  cnt;
      bit  rs;
      cnt = -1;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         rs = rst;
         #1;
         if (rs) begin
            pmem_resp = 1'b0;
            cnt = -1;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            pmem_rdata = rand_line();
         end else if (pmem_read || pmem_write) begin
            if (cnt < 0) cnt = mem_slow ? 20 : $urandom_range(0, 4);
            if (cnt == 0) begin
               pmem_resp = 1'b1;
               pmem_rdata = mem_line(pmem_address);
               cnt = -1;
            end else begin
               cnt--;
            end
         end else if ($urandom_range(0, 9) == 0) begin
            pmem_resp = 1'b1;
            pmem_rdata = rand_line();
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit   in_txn;
      txn_t cur;
      int   exp_start;
      in_txn = 0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_txn = 0;
            continue;
         end
         check("i_rdata_bcast", i_pmem_rdata, pmem_rdata);
         check("d_rdata_bcast", d_pmem_rdata, pmem_rdata);
         if (!in_txn && (pmem_read || pmem_write)) begin
            in_txn = 1;
            if (exp_q.size() == 0) begin
               check("unexpected_txn", 1, 0);
               cur = '0;
               cur.wr = pmem_write;
               cur.addr = pmem_address;
               cur.wd = pmem_wdata;
            end else begin
               cur = exp_q.pop_front();
               exp_start = int'(cur.issue) + 1;
               if (last_end + 2 > exp_start) exp_start = last_end + 2;
               check("start_cycle", cyc, exp_start);
            end
         end
         if (in_txn) begin
            check("pmem_read", pmem_read, !cur.wr);
            check("pmem_write", pmem_write, cur.wr);
            check("pmem_address", pmem_address, cur.addr);
            check("pmem_wdata", pmem_wdata, cur.wd);
            check("state_serve", dbg_state, cur.id ? 2'd2 : 2'd1);
            check("i_resp_route", i_pmem_resp, pmem_resp && !cur.id);
            check("d_resp_route", d_pmem_resp, pmem_resp && cur.id);
            if (pmem_resp) begin
               in_txn = 0;
               last_end = cyc;
            end
         end else begin
            check("idle_i_resp", i_pmem_resp, 0);
            check("idle_d_resp", d_pmem_resp, 0);
            check("idle_state", dbg_state, 2'd0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input bit is_d, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [127:0] wd);
      if (is_d) begin
         d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = wd;
      end else begin
         i_pmem_read = rd; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = wd;
      end
   endtask

   // Holds one request until its resp arrives. If drop is set, the request is
   // released and the address scrambled right after the grant.
   task automatic drive(input bit is_d, input bit wr, input logic [15:0] a,
                        input logic [127:0] wd, input bit drop);
      bit got;
      set_req(is_d, !wr, wr, a, wd);
      if (drop) begin
         @(posedge clk); #1;
         set_req(is_d, 0, 0, 16'hFFFE, rand_line());
      end
      got = 0;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         if (is_d ? d_pmem_resp : i_pmem_resp) begin
            got = 1;
            check(is_d ? "d_rdata_ret" : "i_rdata_ret",
                  is_d ? d_pmem_rdata : i_pmem_rdata, mem_line(a));
         end
      end
      if (!got) check(is_d ? "d_resp_timeout" : "i_resp_timeout", 0, 1);
      @(posedge clk); #1;
      set_req(is_d, 0, 0, a, wd);
   endtask

   // Reference model for one round. I may present one op. D may present one
   // op, or a writeback followed by a fill (chain). The model replays the
   // arbitration rule over the pending sets to predict the grant order.
   task automatic run_round(input bit use_i, input bit i_wr, input logic [15:0] i_addr,
                            input bit use_d, input bit d_wr, input logic [15:0] d_addr,
                            input bit d_chain, input logic [15:0] d_addr2, input bit drop_first);
      txn_t li[$];
      txn_t ld[$];
      txn_t t;
      logic [127:0] i_wd, d_wd, d_wd2;
      bit first, w, first_w, drop_i, drop_d;
      i_wd = rand_line(); d_wd = rand_line(); d_wd2 = rand_line();
      if (d_chain) d_wr = 1'b1;
      if (use_i) li.push_back('{id: 1'b0, wr: i_wr, addr: i_addr, wd: i_wd, issue: 32'd0});
      if (use_d) begin
         ld.push_back('{id: 1'b1, wr: d_wr, addr: d_addr, wd: d_wd, issue: 32'd0});
         if (d_chain) ld.push_back('{id: 1'b1, wr: 1'b0, addr: d_addr2, wd: d_wd2, issue: 32'd0});
      end
      first = 1; first_w = 0;
      while (li.size() != 0 || ld.size() != 0) begin
         if (li.size() != 0 && ld.size() != 0) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            w = (rr_last == 1'b0);
`else
            w = 1'b1;
`endif
         end else begin
            w = (ld.size() != 0);
         end
         t = w ? ld.pop_front() : li.pop_front();
         t.issue = first ? 32'(cyc) : 32'd0;
         if (first) first_w = w;
         first = 0;
         exp_q.push_back(t);
         rr_last = w;
      end
      drop_i = drop_first && !first_w;
      drop_d = drop_first && first_w && !d_chain;
      fork
         begin
            if (use_i) drive(1'b0, i_wr, i_addr, i_wd, drop_i);
         end
         begin
            if (use_d) begin
               drive(1'b1, d_wr, d_addr, d_wd, drop_d);
               if (d_chain) drive(1'b1, 1'b0, d_addr2, d_wd2, 1'b0);
            end
         end
      join
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_pmem_read"}, pmem_read, 0);
      check({tag, "_pmem_write"}, pmem_write, 0);
      check({tag, "_pmem_address"}, pmem_address, 0);
      check({tag, "_pmem_wdata"}, pmem_wdata, 0);
      check({tag, "_i_resp"}, i_pmem_resp, 0);
      check({tag, "_d_resp"}, d_pmem_resp, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ui, ud;
      rst = 1'b1;
      set_req(0, 0, 0, 16'h0, '0);
      set_req(1, 0, 0, 16'h0, '0);
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b0;
      rr_last = 1'b0;

      // Directed scenarios.
      run_round(1, 0, 16'h1230, 0, 0, 16'h0, 0, 16'h0, 0);          // single I read
      run_round(1, 0, 16'h0040, 1, 0, 16'h8000, 0, 16'h0, 0);       // simultaneous pair
      run_round(1, 0, 16'h0044, 1, 0, 16'h8004, 0, 16'h0, 0);       // second pair
      begin
         // Dirty miss with the fixed A5 writeback pattern.
         txn_t t;
         logic [127:0] wd;
         wd = {4{32'hA5A5A5A5}};
         t = '{id: 1'b1, wr: 1'b1, addr: 16'h2200, wd: wd, issue: 32'(cyc)};
         exp_q.push_back(t);
         t = '{id: 1'b1, wr: 1'b0, addr: 16'h3300, wd: wd, issue: 32'd0};
         exp_q.push_back(t);
         rr_last = 1'b1;
         drive(1'b1, 1'b1, 16'h2200, wd, 1'b0);
         drive(1'b1, 1'b0, 16'h3300, wd, 1'b0);
      end
      run_round(0, 0, 16'h0, 1, 0, 16'h5000, 0, 16'h0, 1);          // hold stability

      // Reset during cycle 2 of a D read.
      mem_slow = 1'b1;
      exp_q.push_back('{id: 1'b1, wr: 1'b0, addr: 16'h4444, wd: '0, issue: 32'(cyc)});
      set_req(1, 1, 0, 16'h4444, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      set_req(1, 0, 0, 16'h0, '0);
      @(posedge clk); #1;
      check_quiet("midreset");
      check("midreset_exp_consumed", exp_q.size(), 0);
      rst = 1'b0;
      mem_slow = 1'b0;
      rr_last = 1'b0;
      exp_q.delete();
      run_round(1, 0, 16'h0100, 0, 0, 16'h0, 0, 16'h0, 0);          // fresh I after reset

      // Randomized rounds.
      for (int r = 0; r < 150; r++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         ui = $urandom_range(0, 1);
         ud = $urandom_range(0, 1);
         if (!ui && !ud) ud = 1;
         run_round(ui, 1'($urandom_range(0, 1)), 16'($urandom),
                   ud, 1'($urandom_range(0, 1)), 16'($urandom),
                   ud && ($urandom_range(0, 3) == 0), 16'($urandom),
                   $urandom_range(0, 3) == 0);
      end

      repeat (5) @(posedge clk);
      #1;
      check("exp_q_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
